// File: rtl/alu16_exec_ctrl.sv
// alu16_exec_ctrl: issue-side execution controller for the external alu16.
// Holds the register file and FLAGS (ZF/CF/SF), accepts one command per
// valid/ready handshake, drives op/a/b to alu16 for one EXEC cycle, captures
// y and flags, and presents them on a valid/ready result port. Register and
// FLAGS are updated only when the result handshake completes.
// Optional feature macro: ALU16_EXEC_BYPASS_EN. When defined, a new command
// can be accepted in the same cycle as the result handshake, and any operand
// read of the destination being committed is forwarded from res_data.
module alu16_exec_ctrl #(
  parameter int unsigned NREG = 8,
  localparam int unsigned AW = (NREG > 1) ? $clog2(NREG) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [2:0]    cmd_op,
  input  logic [AW-1:0] cmd_dst,
  input  logic [AW-1:0] cmd_src,
  input  logic          cmd_imm_en,
  input  logic [15:0]   cmd_imm,
  input  logic          cmd_wb,
  output logic [2:0]    alu_op,
  output logic [15:0]   alu_a,
  output logic [15:0]   alu_b,
  input  logic [15:0]   alu_y,
  input  logic          alu_zf,
  input  logic          alu_cf,
  input  logic          alu_sf,
  output logic          res_valid,
  input  logic          res_ready,
  output logic [15:0]   res_data,
  output logic          res_zf,
  output logic          res_cf,
  output logic          res_sf,
  output logic          flags_zf,
  output logic          flags_cf,
  output logic          flags_sf,
  input  logic [AW-1:0] dbg_addr,
  output logic [15:0]   dbg_data
);

  localparam logic [2:0] OP_MOV = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_WB   = 2'd2
  } state_t;

  state_t        state_q;
  state_t        state_d;

  logic [15:0]   regs_q [NREG];

  logic [2:0]    op_q;
  logic [15:0]   a_q;
  logic [15:0]   b_q;
  logic [AW-1:0] dst_q;
  logic          wb_q;

  logic          cmd_hs;
  logic          res_hs;
  logic [15:0]   opnd_a;
  logic [15:0]   opnd_b;
  logic [15:0]   src_val;

  assign res_valid = (state_q == ST_WB);
  assign res_hs    = res_valid & res_ready;

`ifdef ALU16_EXEC_BYPASS_EN
  assign cmd_ready = (state_q == ST_IDLE) | res_hs;
`else
  assign cmd_ready = (state_q == ST_IDLE);
`endif

  assign cmd_hs = cmd_valid & cmd_ready;

  // ALU drive comes straight from the command latches, so it holds outside EXEC.
  assign alu_op = op_q;
  assign alu_a  = a_q;
  assign alu_b  = b_q;

  // Debug port reads the architectural register (pre-commit value).
  assign dbg_data = regs_q[dbg_addr];

  // Operand fetch for the command being accepted this cycle.
  always_comb begin
    opnd_a  = regs_q[cmd_dst];
    src_val = regs_q[cmd_src];
`ifdef ALU16_EXEC_BYPASS_EN
    // The register write lands at the same edge as this read, so take the
    // committing value directly.
    if (res_hs && wb_q && (dst_q == cmd_dst)) begin
      opnd_a = res_data;
    end
    if (res_hs && wb_q && (dst_q == cmd_src)) begin
      src_val = res_data;
    end
`endif
    opnd_b = cmd_imm_en ? cmd_imm : src_val;
  end

  // Next-state logic: IDLE -> EXEC -> WB -> IDLE (or straight to EXEC on overlap).
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (cmd_hs) state_d = ST_EXEC;
      ST_EXEC: state_d = ST_WB;
      ST_WB: begin
        if (res_hs) begin
          state_d = cmd_hs ? ST_EXEC : ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Latch opcode, operands and destination on command acceptance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q  <= '0;
      a_q   <= '0;
      b_q   <= '0;
      dst_q <= '0;
      wb_q  <= 1'b0;
    end else if (cmd_hs) begin
      op_q  <= cmd_op;
      a_q   <= opnd_a;
      b_q   <= opnd_b;
      dst_q <= cmd_dst;
      wb_q  <= cmd_wb;
    end
  end

  // Capture the ALU result and flags verbatim during EXEC.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_data <= '0;
      res_zf   <= 1'b0;
      res_cf   <= 1'b0;
      res_sf   <= 1'b0;
    end else if (state_q == ST_EXEC) begin
      res_data <= alu_y;
      res_zf   <= alu_zf;
      res_cf   <= alu_cf;
      res_sf   <= alu_sf;
    end
  end

  // Register file write on result handshake when write-back is requested.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
    end else if (res_hs && wb_q) begin
      regs_q[dst_q] <= res_data;
    end
  end

  // FLAGS update on result handshake; MOV leaves FLAGS untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_zf <= 1'b0;
      flags_cf <= 1'b0;
      flags_sf <= 1'b0;
    end else if (res_hs && (op_q != OP_MOV)) begin
      flags_zf <= res_zf;
      flags_cf <= res_cf;
      flags_sf <= res_sf;
    end
  end

endmodule

// File: tb/tb_alu16_exec_ctrl.sv
// Testbench for alu16_exec_ctrl: provides a behavioural alu16, a reference
// model of the architectural state, and directed command sequences.
module tb_alu16_exec_ctrl;

  localparam int unsigned NREG = 8;
  localparam int unsigned AW   = 3;

`ifdef ALU16_EXEC_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_MOV = 3'd5;
  localparam logic [2:0] OP_SHL = 3'd6;
  localparam logic [2:0] OP_SHR = 3'd7;

  logic          clk;
  logic          rst_n;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [2:0]    cmd_op;
  logic [AW-1:0] cmd_dst;
  logic [AW-1:0] cmd_src;
  logic          cmd_imm_en;
  logic [15:0]   cmd_imm;
  logic          cmd_wb;
  logic [2:0]    alu_op;
  logic [15:0]   alu_a;
  logic [15:0]   alu_b;
  logic [15:0]   alu_y;
  logic          alu_zf;
  logic          alu_cf;
  logic          alu_sf;
  logic          res_valid;
  logic          res_ready;
  logic [15:0]   res_data;
  logic          res_zf;
  logic          res_cf;
  logic          res_sf;
  logic          flags_zf;
  logic          flags_cf;
  logic          flags_sf;
  logic [AW-1:0] dbg_addr;
  logic [15:0]   dbg_data;

  alu16_exec_ctrl #(.NREG(NREG)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_dst(cmd_dst), .cmd_src(cmd_src), .cmd_imm_en(cmd_imm_en),
    .cmd_imm(cmd_imm), .cmd_wb(cmd_wb),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_y(alu_y),
    .alu_zf(alu_zf), .alu_cf(alu_cf), .alu_sf(alu_sf),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_zf(res_zf), .res_cf(res_cf), .res_sf(res_sf),
    .flags_zf(flags_zf), .flags_cf(flags_cf), .flags_sf(flags_sf),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] y;
    logic        zf;
    logic        cf;
    logic        sf;
  } alu_res_t;

  // Behavioural alu16: CF is carry-out for ADD and borrow for SUB, 0 otherwise.
  function automatic alu_res_t alu_fn(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
    alu_res_t    r;
    logic [16:0] t;
    r.y  = '0;
    r.cf = 1'b0;
    case (op)
      3'd0: begin t = {1'b0, a} + {1'b0, b}; r.y = t[15:0]; r.cf = t[16]; end
      3'd1: begin t = {1'b0, a} - {1'b0, b}; r.y = t[15:0]; r.cf = t[16]; end
      3'd2: r.y = a & b;
      3'd3: r.y = a | b;
      3'd4: r.y = a ^ b;
      3'd5: r.y = b;
      3'd6: r.y = a << b[3:0];
      default: r.y = a >> b[3:0];
    endcase
    r.zf = (r.y == 16'h0000);
    r.sf = r.y[15];
    return r;
  endfunction

  alu_res_t alu_r;
  always_comb alu_r = alu_fn(alu_op, alu_a, alu_b);
  assign alu_y  = alu_r.y;
  assign alu_zf = alu_r.zf;
  assign alu_cf = alu_r.cf;
  assign alu_sf = alu_r.sf;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int last_cmd_cyc = 0;
  int last_res_cyc = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=0x%04h required=0x%04h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: architectural registers/FLAGS plus in-flight commands.
  typedef struct {
    logic [2:0]    op;
    logic [15:0]   a;
    logic [15:0]   b;
    logic [AW-1:0] dst;
    logic          wb;
    alu_res_t      r;
    int            acc;
  } ent_t;

  logic [15:0] m_regs [NREG];
  logic        m_zf, m_cf, m_sf;
  ent_t        q[$];

  // Per-cycle comparison against the model, then advance the model across
  // the handshakes that will occur at the coming rising edge.
  always @(negedge clk) begin
    logic  exp_rv;
    logic  exp_cr;
    ent_t  e;
    cyc++;
    if (!rst_n) begin
      check("rst_res_valid", res_valid, 1'b0);
      check("rst_res_data", res_data, 16'h0000);
      check("rst_flags", {flags_zf, flags_cf, flags_sf}, 3'b000);
      check("rst_alu_a", alu_a, 16'h0000);
      check("rst_alu_b", alu_b, 16'h0000);
      check("rst_alu_op", alu_op, 3'd0);
      check("rst_dbg", dbg_data, 16'h0000);
      q.delete();
      for (int i = 0; i < NREG; i++) m_regs[i] = '0;
      m_zf = 1'b0; m_cf = 1'b0; m_sf = 1'b0;
    end else begin
      exp_rv = (q.size() > 0) && (cyc >= q[0].acc + 2);
      exp_cr = (q.size() == 0) || (BYP && exp_rv && res_ready);
      check("res_valid", res_valid, exp_rv);
      check("cmd_ready", cmd_ready, exp_cr);
      check("flags", {flags_zf, flags_cf, flags_sf}, {m_zf, m_cf, m_sf});
      check("dbg_data", dbg_data, m_regs[dbg_addr]);
      if (exp_rv) begin
        check("res_data", res_data, q[0].r.y);
        check("res_flags", {res_zf, res_cf, res_sf}, {q[0].r.zf, q[0].r.cf, q[0].r.sf});
      end
      if ((q.size() > 0) && (cyc == q[0].acc + 1)) begin
        check("alu_op", alu_op, q[0].op);
        check("alu_a", alu_a, q[0].a);
        check("alu_b", alu_b, q[0].b);
      end
      if (exp_rv && res_ready) begin
        e = q.pop_front();
        if (e.wb) m_regs[e.dst] = e.r.y;
        if (e.op != OP_MOV) begin
          m_zf = e.r.zf; m_cf = e.r.cf; m_sf = e.r.sf;
        end
        last_res_cyc = cyc;
      end
      if (cmd_valid && cmd_ready) begin
        e.op  = cmd_op;
        e.a   = m_regs[cmd_dst];
        e.b   = cmd_imm_en ? cmd_imm : m_regs[cmd_src];
        e.dst = cmd_dst;
        e.wb  = cmd_wb;
        e.r   = alu_fn(cmd_op, e.a, e.b);
        e.acc = cyc;
        q.push_back(e);
        last_cmd_cyc = cyc;
      end
    end
  end

  // Present a command and wait (bounded) for acceptance; returns just after the accepting edge.
  task automatic send(input logic [2:0] op, input logic [AW-1:0] dst, input logic [AW-1:0] src,
                      input logic imm_en, input logic [15:0] imm, input logic wb);
    bit ok;
    ok = 1'b0;
    cmd_op = op; cmd_dst = dst; cmd_src = src;
    cmd_imm_en = imm_en; cmd_imm = imm; cmd_wb = wb;
    cmd_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (cmd_ready) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      n_checks++; n_fail++;
      $display("FAIL cmd_accept_timeout actual=no_ready required=ready");
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  // Wait (bounded) for res_valid; returns at that falling edge with the result.
  task automatic get_res(output logic [15:0] d, output logic z, output logic c, output logic s);
    bit ok;
    ok = 1'b0;
    d = '0; z = 1'b0; c = 1'b0; s = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (res_valid) begin
        ok = 1'b1;
        d = res_data; z = res_zf; c = res_cf; s = res_sf;
        break;
      end
    end
    if (!ok) begin
      n_checks++; n_fail++;
      $display("FAIL res_valid_timeout actual=no_valid required=valid");
    end
  endtask

  logic [15:0] d;
  logic        z, c, s;
  int          t0, t1;

  logic [2:0]  tab_op  [5] = '{OP_AND, OP_OR, OP_SHL, OP_SHR, OP_XOR};
  logic [15:0] tab_imm [5] = '{16'h00FF, 16'hF000, 16'h0004, 16'h0004, 16'h000F};
  logic [15:0] tab_exp [5] = '{16'h000F, 16'hF00F, 16'h00F0, 16'h000F, 16'h0000};

  initial begin
    rst_n = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_dst = '0; cmd_src = '0;
    cmd_imm_en = 1'b0; cmd_imm = '0; cmd_wb = 1'b0; res_ready = 1'b1; dbg_addr = '0;
    #3 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_cmd_ready", cmd_ready, 1'b1);

    // 1: MOV r0,#0x1234 ; ADD r0,#0xEDCC wraps to zero with carry
    send(OP_MOV, 3'd0, 3'd0, 1'b1, 16'h1234, 1'b1);
    get_res(d, z, c, s); @(posedge clk); #1;
    send(OP_ADD, 3'd0, 3'd0, 1'b1, 16'hEDCC, 1'b1);
    get_res(d, z, c, s);
    check("t1_data", d, 16'h0000);
    check("t1_zcs", {z, c, s}, 3'b110);
    @(posedge clk); #1;
    dbg_addr = 3'd0; #1;
    check("t1_r0", dbg_data, 16'h0000);

    // 2: MOV r1,#5 ; SUB r1,#7 flags-only
    send(OP_MOV, 3'd1, 3'd0, 1'b1, 16'h0005, 1'b1);
    get_res(d, z, c, s); @(posedge clk); #1;
    send(OP_SUB, 3'd1, 3'd0, 1'b1, 16'h0007, 1'b0);
    get_res(d, z, c, s);
    check("t2_data", d, 16'hFFFE);
    check("t2_sf_zf", {s, z}, 2'b10);
    @(posedge clk); #1;
    dbg_addr = 3'd1; #1;
    check("t2_r1", dbg_data, 16'h0005);
    check("t2_flags_sf", flags_sf, 1'b1);

    // 3: backpressure for 5 cycles on ADD r1,#1
    res_ready = 1'b0;
    send(OP_ADD, 3'd1, 3'd0, 1'b1, 16'h0001, 1'b1);
    get_res(d, z, c, s);
    check("t3_data", d, 16'h0006);
    repeat (5) begin
      @(posedge clk); #1;
      check("t3_hold_valid", res_valid, 1'b1);
      check("t3_hold_data", res_data, 16'h0006);
      check("t3_hold_cmd_ready", cmd_ready, 1'b0);
      check("t3_hold_r1", dbg_data, 16'h0005);
    end
    res_ready = 1'b1;
    @(posedge clk); #1;
    check("t3_r1_commit", dbg_data, 16'h0006);
    check("t3_valid_drop", res_valid, 1'b0);

    // 4: XOR r5,r5 sets ZF; MOV r2,#0x8000 must not touch FLAGS
    send(OP_XOR, 3'd5, 3'd5, 1'b0, 16'h0000, 1'b1);
    get_res(d, z, c, s); @(posedge clk); #1;
    check("t4_pre_zf_sf", {flags_zf, flags_sf}, 2'b10);
    send(OP_MOV, 3'd2, 3'd0, 1'b1, 16'h8000, 1'b1);
    get_res(d, z, c, s);
    check("t4_res_sf", s, 1'b1);
    @(posedge clk); #1;
    dbg_addr = 3'd2; #1;
    check("t4_r2", dbg_data, 16'h8000);
    check("t4_flags_zf_sf", {flags_zf, flags_sf}, 2'b10);

    // 5: reset during EXEC of MOV r3,#0xAAAA
    send(OP_MOV, 3'd3, 3'd0, 1'b1, 16'hAAAA, 1'b1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    dbg_addr = 3'd3; #1;
    check("t5_res_valid", res_valid, 1'b0);
    check("t5_r3", dbg_data, 16'h0000);
    check("t5_flags", {flags_zf, flags_cf, flags_sf}, 3'b000);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("t5_r3_after", dbg_data, 16'h0000);
    send(OP_MOV, 3'd3, 3'd0, 1'b1, 16'h1111, 1'b1);
    get_res(d, z, c, s); @(posedge clk); #1;
    check("t5_r3_new", dbg_data, 16'h1111);

    // 6: MOV r4,#1 then ADD r4,r4 back to back
    send(OP_MOV, 3'd4, 3'd0, 1'b1, 16'h0001, 1'b1);
    t0 = last_cmd_cyc;
    send(OP_ADD, 3'd4, 3'd4, 1'b0, 16'h0000, 1'b1);
    t1 = last_cmd_cyc;
    get_res(d, z, c, s);
    check("t6_data", d, 16'h0002);
    @(posedge clk); #1;
    dbg_addr = 3'd4; #1;
    check("t6_r4", dbg_data, 16'h0002);
    // Accept-to-accept spacing, and first accept to final commit.
    check("t6_accept_gap", 16'(t1 - t0), BYP ? 16'd2 : 16'd3);
    check("t6_total", 16'(last_res_cyc - t0), BYP ? 16'd4 : 16'd5);

    // Logic and shift chain on r6
    send(OP_MOV, 3'd6, 3'd0, 1'b1, 16'h0F0F, 1'b1);
    get_res(d, z, c, s); @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      send(tab_op[i], 3'd6, 3'd0, 1'b1, tab_imm[i], 1'b1);
      get_res(d, z, c, s);
      check("chain_data", d, tab_exp[i]);
      @(posedge clk); #1;
    end
    dbg_addr = 3'd6; #1;
    check("chain_zf", flags_zf, 1'b1);

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
